// File: rtl/bg_pixel_pipe.sv
// ---------------------------------------------------------------------------
// bg_pixel_pipe
//   Background/window pixel pipeline for the PPU draw phase. A four-state
//   tile fetcher walks the tile map, reads two bytes of tile data through a
//   single-port VRAM with one cycle of read latency, and pushes eight pixels
//   at a time into a small pixel FIFO. The LCD stage pops one pixel per
//   cycle. Fine horizontal scroll is applied by silently dropping the first
//   scx[2:0] pixels. The window is switched in mid-line by flushing the FIFO
//   and restarting the fetcher on the window map.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle pulse: begin line `ly` (aborts a line in progress)
//   ly           line number, sampled on start
//   lcdc         LCD control register (tile maps, tile data mode, enables)
//   scx, scy     background scroll, sampled on start
//   wx, wy       window position, sampled on start (wy compared on start)
//   vram_addr    VRAM byte address (0x8000-relative)
//   vram_in      VRAM read data, valid the cycle after the address
//   pix_valid    pix_out holds a visible pixel
//   pix_out      colour index (0 when the background is disabled)
//   pop          consumer takes pix_out this cycle
//   lx           x index of the pixel being presented
//   busy         line in progress
//   line_done    one-cycle pulse after the last pixel of the line is popped
// ---------------------------------------------------------------------------
package bg_pixel_pkg;
   typedef struct packed {
      logic lcd_ena;
      logic win_tile_map;
      logic win_ena;
      logic bg_win_tile_data;
      logic bg_tile_map;
      logic obj_size;
      logic obj_ena;
      logic bg_ena;
   } lcdc_t;
endpackage

module bg_pixel_pipe
   import bg_pixel_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int BPP        = 2,
   parameter int LINE_W     = 160
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [7:0]     ly,
   input  lcdc_t          lcdc,
   input  logic [7:0]     scx,
   input  logic [7:0]     scy,
   input  logic [7:0]     wx,
   input  logic [7:0]     wy,
   output logic [12:0]    vram_addr,
   input  logic [7:0]     vram_in,
   output logic           pix_valid,
   output logic [BPP-1:0] pix_out,
   input  logic           pop,
   output logic [7:0]     lx,
   output logic           busy,
   output logic           line_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TILE,
      S_LOW,
      S_HIGH,
      S_PUSH
   } state_t;

   state_t         r_state;
   logic           r_busy;
   logic [7:0]     r_lx;
   logic           r_line_done;
   logic [2:0]     r_discard;
   logic [7:0]     r_row;
   logic [4:0]     r_col;
   logic [7:0]     r_tile_id;
   logic [7:0]     r_low;
   logic           r_win_mode;
   logic           r_win_latch;
   logic [7:0]     r_win_ly;
   logic [7:0]     r_wx;
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic [BPP-1:0] r_fifo [FIFO_DEPTH];

   logic [7:0]     w_win_x;
   logic           w_win_in_line;
   logic           w_win_trig;
   logic           w_fifo_empty;
   logic           w_pix_valid;
   logic           w_rd;
   logic           w_free_ok;
   logic           w_push;
   logic           w_last_pop;
   logic           w_map_sel;
   logic [12:0]    w_vram_addr;
   logic [BPP-1:0] w_head;
   logic [BPP-1:0] w_push_pix [8];
   logic           w_unused;

   // Register bits this block has no use for.
   assign w_unused = &{1'b0, lcdc.lcd_ena, lcdc.obj_size, lcdc.obj_ena};

   // Tile data address for both addressing modes. In signed mode the tile id
   // is a two's-complement offset from 0x1000, which reduces to flipping the
   // top address bit relative to the id's sign bit.
   function automatic logic [12:0] f_data_addr(input logic [7:0] id,
                                               input logic [2:0] fy,
                                               input logic       h,
                                               input logic       unsigned_mode);
      if (unsigned_mode)
         return {1'b0, id, fy, h};
      else
         return {~id[7], id[7], id[6:0], fy, h};
   endfunction

   // Window start column; wx below 7 clamps to the left edge.
   assign w_win_x       = (r_wx < 8'd7) ? 8'd0 : r_wx - 8'd7;
   assign w_win_in_line = (int'(r_wx) < LINE_W + 7);

   // The trigger pre-empts the pixel sitting at lx this cycle, so it also
   // masks pix_valid and blocks any read or push.
   assign w_win_trig = r_busy && r_win_latch && lcdc.win_ena && !r_win_mode &&
                       w_win_in_line && (r_lx == w_win_x);

   assign w_fifo_empty = (r_count == '0);
   assign w_pix_valid  = r_busy && !w_fifo_empty && (r_discard == 3'd0) && !w_win_trig;
   assign w_rd         = r_busy && !w_fifo_empty && !w_win_trig &&
                         ((r_discard != 3'd0) || pop);
   assign w_free_ok    = (r_count <= CW'(FIFO_DEPTH - 8));
   assign w_push       = (r_state == S_PUSH) && w_free_ok && !w_win_trig;
   assign w_last_pop   = w_pix_valid && pop && (r_lx == 8'(LINE_W - 1));
   assign w_map_sel    = r_win_mode ? lcdc.win_tile_map : lcdc.bg_tile_map;

   // Eight pixels of the tile row, leftmost (bit 7) first.
   for (genvar gi = 0; gi < 8; gi++) begin : g_push_pix
      assign w_push_pix[gi] = BPP'({vram_in[7-gi], r_low[7-gi]});
   end

   // The low-byte address is formed straight from vram_in because the tile
   // id only arrives in that same cycle; from HIGH onward the captured copy
   // is used. PUSH keeps the high-byte address so vram_in stays valid while
   // the fetcher waits for FIFO room.
   always_comb begin
      w_vram_addr = '0;
      case (r_state)
         S_TILE:         w_vram_addr = {2'b11, w_map_sel, r_row[7:3], r_col};
         S_LOW:          w_vram_addr = f_data_addr(vram_in, r_row[2:0], 1'b0,
                                                   lcdc.bg_win_tile_data);
         S_HIGH, S_PUSH: w_vram_addr = f_data_addr(r_tile_id, r_row[2:0], 1'b1,
                                                   lcdc.bg_win_tile_data);
         default:        w_vram_addr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_lx        <= '0;
         r_line_done <= 1'b0;
         r_discard   <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_tile_id   <= '0;
         r_low       <= '0;
         r_win_mode  <= 1'b0;
         r_win_latch <= 1'b0;
         r_win_ly    <= '0;
         r_wx        <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else if (start) begin
         r_state     <= S_TILE;
         r_busy      <= 1'b1;
         r_lx        <= '0;
         r_line_done <= 1'b0;
         r_discard   <= scx[2:0];
         r_row       <= ly + scy;
         r_col       <= scx[7:3];
         r_win_mode  <= 1'b0;
         r_wx        <= wx;
         // The y latch survives across lines until the frame restarts at ly 0.
         r_win_latch <= ((ly != 8'd0) && r_win_latch) || (lcdc.win_ena && (ly == wy));
         if (ly == 8'd0)
            r_win_ly <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_line_done <= 1'b0;
         if (w_last_pop) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_lx        <= '0;
            r_line_done <= 1'b1;
            r_discard   <= '0;
            r_win_ly    <= r_win_ly + {7'd0, r_win_mode};
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
         end else if (w_win_trig) begin
            r_state    <= S_TILE;
            r_win_mode <= 1'b1;
            r_row      <= r_win_ly;
            r_col      <= '0;
            r_discard  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
         end else begin
            case (r_state)
               S_TILE: r_state <= S_LOW;
               S_LOW: begin
                  r_tile_id <= vram_in;
                  r_state   <= S_HIGH;
               end
               S_HIGH: begin
                  r_low   <= vram_in;
                  r_state <= S_PUSH;
               end
               S_PUSH: begin
                  if (w_free_ok) begin
                     r_col   <= r_col + 5'd1;
                     r_state <= S_TILE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase

            if (w_push)
               r_wr_ptr <= r_wr_ptr + PW'(8);

            // Reads either drop a fine-scroll pixel or hand one to the consumer.
            if (w_rd) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
               if (r_discard != 3'd0)
                  r_discard <= r_discard - 3'd1;
               else
                  r_lx <= r_lx + 8'd1;
            end

            r_count <= r_count + (w_push ? CW'(8) : CW'(0)) - (w_rd ? CW'(1) : CW'(0));
         end
      end
   end

   // Pixel storage; occupancy is tracked above, so the data needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int k = 0; k < 8; k++)
            r_fifo[r_wr_ptr + PW'(k)] <= w_push_pix[k];
      end
   end

   assign w_head    = r_fifo[r_rd_ptr];
   assign vram_addr = w_vram_addr;
   assign pix_valid = w_pix_valid;
   assign pix_out   = (w_pix_valid && lcdc.bg_ena) ? w_head : '0;
   assign lx        = r_lx;
   assign busy      = r_busy;
   assign line_done = r_line_done;

endmodule

// File: tb/tb_bg_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tb_bg_pixel_pipe
//   Scoreboard bench for bg_pixel_pipe. A behavioural VRAM with one cycle of
//   read latency feeds the DUT. When a line is started the bench computes the
//   whole expected line from its own model of scrolling, window and tile
//   addressing and queues it; each popped pixel is compared against the
//   queue head.
// ---------------------------------------------------------------------------
module tb_bg_pixel_pipe;
   import bg_pixel_pkg::*;

   localparam int LINE_W = 160;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  ly;
   lcdc_t       lcdc;
   logic [7:0]  scx, scy, wx, wy;
   logic [12:0] vram_addr;
   logic [7:0]  vram_in;
   logic        pix_valid;
   logic [1:0]  pix_out;
   logic        pop;
   logic [7:0]  lx;
   logic        busy;
   logic        line_done;

   bg_pixel_pipe #(
      .FIFO_DEPTH (16),
      .BPP        (2),
      .LINE_W     (LINE_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ly        (ly),
      .lcdc      (lcdc),
      .scx       (scx),
      .scy       (scy),
      .wx        (wx),
      .wy        (wy),
      .vram_addr (vram_addr),
      .vram_in   (vram_in),
      .pix_valid (pix_valid),
      .pix_out   (pix_out),
      .pop       (pop),
      .lx        (lx),
      .busy      (busy),
      .line_done (line_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural VRAM: data for an address appears the following cycle.
   logic [7:0] vram [8192];
   always @(posedge clk) vram_in <= vram[vram_addr];

   typedef struct {
      logic [1:0] pix;
      int         lx;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          popped;
   int          cur_ly;
   int          first_valid;
   int          line_cycles;
   logic [12:0] addr_log [16];
   logic [1:0]  pix_log [8];

   // Reference model state for the window.
   bit          m_latch = 0;
   int          m_win_ly = 0;
   bit          m_win_line = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (ly=%0d px=%0d t=%0t)",
                  tag, got, exp, cur_ly, popped, $time);
      end
   endtask

   function automatic logic [12:0] m_data_addr(input logic [7:0] id, input int fy, input int h);
      int base;
      if (lcdc.bg_win_tile_data) base = 16 * int'(id);
      else                       base = 'h1000 + 16 * int'($signed(id));
      return 13'(base + 2 * fy + h);
   endfunction

   function automatic logic [12:0] m_map_addr(input int sel, input int row, input int col);
      return 13'('h1800 + 'h400 * sel + 32 * (row / 8) + col);
   endfunction

   function automatic logic [1:0] m_pixel(input int x, input int ly_v);
      int ws, row, col, bitn, sel, px;
      logic [7:0]  id, lo, hi;
      logic [12:0] a;
      ws = (int'(wx) < 7) ? 0 : int'(wx) - 7;
      if (!lcdc.bg_ena) return 2'b00;
      if (m_win_line && x >= ws) begin
         sel  = int'(lcdc.win_tile_map);
         row  = m_win_ly;
         col  = (x - ws) / 8;
         bitn = (x - ws) % 8;
      end else begin
         sel  = int'(lcdc.bg_tile_map);
         row  = (ly_v + int'(scy)) % 256;
         px   = (x + int'(scx)) % 256;
         col  = px / 8;
         bitn = px % 8;
      end
      id = vram[m_map_addr(sel, row, col)];
      a  = m_data_addr(id, row % 8, 0);
      lo = vram[a];
      hi = vram[a + 13'd1];
      return {hi[7 - bitn], lo[7 - bitn]};
   endfunction

   // Pulse start for one cycle and queue the expected line. Returns at T+1.
   task automatic start_line(input int ly_v);
      exp_t e;
      sb.delete();
      popped = 0;
      cur_ly = ly_v;
      if (ly_v == 0) begin
         m_latch  = 0;
         m_win_ly = 0;
      end
      if (lcdc.win_ena && ly_v == int'(wy)) m_latch = 1;
      m_win_line = m_latch && lcdc.win_ena && (int'(wx) < LINE_W + 7);
      for (int x = 0; x < LINE_W; x++) begin
         e.pix = m_pixel(x, ly_v);
         e.lx  = x;
         sb.push_back(e);
      end
      ly    = 8'(ly_v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Pop n_pix pixels (pop held high), comparing each with the scoreboard.
   // If the line completes, checks the line_done pulse and end state.
   task automatic consume(input int n_pix);
      exp_t e;
      int cyc = 0;
      int got = 0;
      first_valid = -1;
      while (got < n_pix && cyc < 1000) begin
         cyc++;
         pop = 1'b1;
         if (cyc < 16) addr_log[cyc] = vram_addr;
         if (pix_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (sb.size() == 0) begin
               check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_val("pix_out", 32'(pix_out), 32'(e.pix));
               check_val("lx", 32'(lx), 32'(e.lx));
            end
            if (popped < 8) pix_log[popped] = pix_out;
            popped++;
            got++;
         end
         @(posedge clk); #1;
      end
      pop = 1'b0;
      line_cycles = cyc;
      check_val("pop_count", 32'(got), 32'(n_pix));
      if (popped == LINE_W) begin
         check_val("line_done_pulse", 32'(line_done), 32'd1);
         check_val("busy_after_line", 32'(busy), 32'd0);
         check_val("sb_empty", 32'(sb.size()), 32'd0);
         $display("line ly=%0d pixels=%0d cycles=%0d window=%0d", cur_ly, popped, cyc, m_win_line);
         @(posedge clk); #1;
         check_val("line_done_one_cycle", 32'(line_done), 32'd0);
         if (m_win_line) m_win_ly++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
      check_val({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check_val({tag, "_pix_out"},   32'(pix_out),   32'd0);
      check_val({tag, "_lx"},        32'(lx),        32'd0);
      check_val({tag, "_busy"},      32'(busy),      32'd0);
      check_val({tag, "_line_done"}, 32'(line_done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  exp_pix [8];
      logic [12:0] exp_addr;
      logic [7:0]  id;

      for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom_range(0, 255));

      rst   = 1'b1;
      start = 1'b0;
      pop   = 1'b0;
      ly    = '0;
      scx   = '0;
      scy   = '0;
      wx    = '0;
      wy    = '0;
      lcdc  = '0;
      lcdc.lcd_ena          = 1'b1;
      lcdc.bg_ena           = 1'b1;
      lcdc.win_tile_map     = 1'b1;
      lcdc.bg_win_tile_data = 1'b1;
      cur_ly = 0;
      popped = 0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic fetch: known tile, address trace and first-pixel latency.
      vram[13'h1800] = 8'h01;
      vram[13'h0010] = 8'hF0;
      vram[13'h0011] = 8'hCC;
      start_line(0);
      consume(LINE_W);
      check_val("addr_map",  32'(addr_log[1]), 32'h1800);
      check_val("addr_low",  32'(addr_log[2]), 32'h0010);
      check_val("addr_high", 32'(addr_log[3]), 32'h0011);
      check_val("first_valid_cycle", 32'(first_valid), 32'd5);
      check_val("line_cycles_scx0", 32'(line_cycles), 32'd164);
      exp_pix = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
      for (int i = 0; i < 8; i++) check_val("tile_pix", 32'(pix_log[i]), 32'(exp_pix[i]));

      // Signed tile-data addressing.
      lcdc.bg_win_tile_data = 1'b0;
      vram[13'h1800] = 8'h80;
      vram[13'h1801] = 8'h7F;
      start_line(0);
      consume(LINE_W);
      check_val("addr_signed_80", 32'(addr_log[2]), 32'h0800);
      check_val("addr_signed_7f", 32'(addr_log[6]), 32'h17F0);
      lcdc.bg_win_tile_data = 1'b1;

      // Fine scroll: five pixels dropped, one extra cycle each.
      scx = 8'd13;
      scy = 8'd20;
      start_line(5);
      consume(LINE_W);
      check_val("line_cycles_scx13", 32'(line_cycles), 32'd169);

      // Coarse scroll near the right edge so the map column wraps 31 -> 0.
      scx = 8'hF5;
      scy = 8'd0;
      start_line(9);
      consume(LINE_W);

      // Window at lx 80 for three lines, a line without it, then again.
      scx = 8'd0;
      wy  = 8'd0;
      wx  = 8'd87;
      lcdc.win_ena = 1'b1;
      for (int l = 0; l < 3; l++) begin
         start_line(l);
         consume(LINE_W);
         check_val("line_cycles_window", 32'(line_cycles), 32'd169);
      end
      lcdc.win_ena = 1'b0;
      start_line(3);
      consume(LINE_W);
      lcdc.win_ena = 1'b1;
      start_line(4);
      consume(LINE_W);
      check_val("win_ly_after_gap", 32'(m_win_ly), 32'd4);
      lcdc.win_ena = 1'b0;

      // Back-pressure: hold pop low, fetcher parks in PUSH on the third tile.
      scx = 8'd0;
      scy = 8'd8;
      id       = vram[m_map_addr(int'(lcdc.bg_tile_map), 11, 2)];
      exp_addr = m_data_addr(id, 3, 1);
      start_line(3);
      for (int i = 1; i < 20; i++) begin
         pop = 1'b0;
         @(posedge clk); #1;
      end
      check_val("stall_addr", 32'(vram_addr), 32'(exp_addr));
      check_val("stall_valid", 32'(pix_valid), 32'd1);
      check_val("stall_lx", 32'(lx), 32'd0);
      check_val("stall_pix", 32'(pix_out), 32'(sb[0].pix));
      consume(LINE_W);

      // Abort at pixel 50 with a new start.
      scy = 8'd0;
      start_line(7);
      consume(50);
      start_line(8);
      check_val("abort_lx", 32'(lx), 32'd0);
      check_val("abort_valid", 32'(pix_valid), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd1);
      check_val("abort_no_done", 32'(line_done), 32'd0);
      consume(LINE_W);

      // Reset in the middle of a line.
      start_line(20);
      consume(30);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      rst = 1'b0;
      sb.delete();
      m_latch  = 0;
      m_win_ly = 0;

      // Background disabled: every pixel reads as colour 0.
      lcdc.bg_ena = 1'b0;
      start_line(0);
      consume(LINE_W);
      lcdc.bg_ena = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bg_pixel_pipe.md
# bg_pixel_pipe

Background/window pixel pipeline for the PPU draw phase: a tile fetcher that walks the tile map, reads tile data over the single-port VRAM, and loads a parametrised pixel FIFO that the LCD output stage pops one pixel per cycle. Generalises the half-speed single-tile fetcher. It runs at full clock rate with 1-cycle VRAM read latency, and adds both tile-data addressing modes, SCX fine-scroll discard, window switch-in with an internal window line counter, back-pressure, and line-complete signalling.

## Interface
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, multiple of 8, ≥16.
- BPP, 2, bits per pixel colour index.
- LINE_W, 160, visible pixels per line.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin line `ly`; aborts any line in progress.
- ly  in  8  current line, sampled on `start`.
- lcdc  in  lcdc_t  uses `bg_ena`, `win_ena`, `win_tile_map`, `bg_tile_map`, `bg_win_tile_data`.
- scx, scy, wx, wy  in  8 each  scroll and window registers, sampled on `start`.
- vram_addr  out  13  VRAM byte address (0x8000-relative).
- vram_in  in  8  VRAM read data, valid the cycle after the address.
- pix_valid  out  1  `pix_out` is a visible pixel.
- pix_out  out  BPP  colour index; 0 when `lcdc.bg_ena`=0.
- pop  in  1  consumer takes `pix_out`; ignored when `pix_valid`=0.
- lx  out  8  index of the pixel currently presented, 0..LINE_W-1.
- busy  out  1  line in progress.
- line_done  out  1  one-cycle pulse after the last pixel is popped.

## Operation
- Fetcher FSM: IDLE → TILE → LOW → HIGH → PUSH → TILE …
  - TILE: drive the map address.
  - LOW: capture tile_id; drive the low data address.
  - HIGH: capture the low byte; drive the high data address.
  - PUSH: `vram_addr` is held, so `vram_in` is the high byte.
    - If FIFO free ≥ 8: write 8 pixels, MSB (bit 7) first, each as {high[k], low[k]}; advance the column; go to TILE.
    - Otherwise stall in PUSH.
- Map address: {2'b11, map_sel, row[7:3], col[4:0]}.
  - Background: map_sel = `bg_tile_map`, row = ly+scy (mod 256), col starts at scx[7:3] and increments mod 32.
  - Window: map_sel = `win_tile_map`, row = win_ly, col starts at 0.
- Data address, with fy = row[2:0] and h = 0 for the low byte, 1 for the high byte:
  - `bg_win_tile_data`=1: {1'b0, tile_id, fy, h}.
  - `bg_win_tile_data`=0: {~tile_id[7], tile_id[7], tile_id[6:0], fy, h} (signed, base 0x1000).
- Fine scroll: after `start`, drop the first scx[2:0] FIFO pixels internally, one per cycle while the FIFO is non-empty. `pix_valid` stays 0 during the drop.
- Window y latch:
  - On `start`: cleared when ly==0; then set if `win_ena` and ly==wy.
  - `win_ly`: reset to 0 on `start` with ly==0; incremented at `line_done` if the window was triggered that line.
- Window trigger: once per line, when the y latch is set, `win_ena`=1 and lx == max(wx-7, 0).
  - Flush the FIFO and restart the fetcher in TILE, window mode.
  - `pix_valid`=0 until the first window tile is pushed.
  - `lx` does not advance during the refill.
  - wx ≥ LINE_W+7 never triggers.
- `pop` with `pix_valid`: FIFO read, lx+1. When lx reaches LINE_W-1 and is popped: pulse `line_done`, go to IDLE, empty the FIFO.
- FIFO write (PUSH) and read (pop/drop) in the same cycle are both performed; occupancy changes by +8-1.

## Timing
- Reset values: vram_addr=0, pix_valid=0, pix_out=0, lx=0, busy=0, line_done=0. FSM in IDLE, FIFO empty, win_ly=0, y latch cleared.
- `start` at cycle T: TILE at T+1, first push at T+4, first `pix_valid` at T+5 when scx[2:0]=0; each discarded pixel adds 1 cycle.
- Steady state: 4 cycles per 8 pixels. A consumer popping every cycle never sees `pix_valid`=0 except at line start and window switch-in.
- `start` while busy: same-cycle abort; T+1 behaves as a fresh line; no `line_done` for the aborted line.
- `rst` overrides `start`.
- `pix_out` and `lx` are stable while `pix_valid`=1 and `pop`=0.

## Test plan
- Map entry 0 = 0x01; data 0x8010=0xF0, 0x8011=0xCC; bg_win_tile_data=1, scx=scy=0, start ly=0 → vram_addr 0x1800, 0x0010, 0x0011 on T+1..T+3; pixels 3,3,1,1,2,2,0,0; `pix_valid` at T+5.
- bg_win_tile_data=0, tile_id 0x80 then 0x7F → data addresses 0x0800 and 0x17F0.
- scx=13, pop held high → first pixel is bit 2 of tile column 1 (0-indexed tile, pixel 5); 160 pops then `line_done` pulse; col wraps 31→0.
- wy=0, wx=87, win_ena=1, three lines → window fetched from col 0 starting at lx=80; win_ly row = 0, 1, 2; a line with win_ena=0 does not increment win_ly.
- `pop` held low for 20 cycles → FIFO fills to 16, fetcher stalls in PUSH; resuming pops loses no pixels and keeps the order.
- `start` at pixel 50 of a line → no `line_done`, lx=0 at T+1, FIFO empty; `rst` mid-line → all outputs at their reset values the next cycle.
